// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/stall control bundle between the 5-stage pipeline datapath and its stall sequencer.
// The pipeline side is the master; the stall controller is the slave.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       readRegSel1_FD;
    logic [2:0]       readRegSel2_FD;
    logic             r1_used_FD;
    logic             r2_used_FD;
    logic             halt_FD;
    logic             memRead_DX;
    logic             regWrite_DX;
    logic [2:0]       writeRegSel_DX;
    logic             redirect_XM;
    logic             imem_stall;
    logic             dmem_stall;
    logic             pc_write;
    logic             fd_write;
    logic             fd_bubble;
    logic             dx_write;
    logic             dx_bubble;
    logic             xm_write;
    logic             mwb_write;
    logic [2:0]       state;
    logic             halted;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output readRegSel1_FD, readRegSel2_FD, r1_used_FD, r2_used_FD, halt_FD,
               memRead_DX, regWrite_DX, writeRegSel_DX, redirect_XM,
               imem_stall, dmem_stall,
        input  pc_write, fd_write, fd_bubble, dx_write, dx_bubble, xm_write,
               mwb_write, state, halted, err_timeout, stall_cnt
    );

    modport slave (
        input  readRegSel1_FD, readRegSel2_FD, r1_used_FD, r2_used_FD, halt_FD,
               memRead_DX, regWrite_DX, writeRegSel_DX, redirect_XM,
               imem_stall, dmem_stall,
        output pc_write, fd_write, fd_bubble, dx_write, dx_bubble, xm_write,
               mwb_write, state, halted, err_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the F/D/X/M/WB pipeline: per-stage write enables and bubbles,
// HALT drain sequencing, saturating stall statistics and a data-memory wait watchdog.
module pipe_stall_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int DRAIN   = 3
) (
    input logic              clk,
    input logic              rst,
    pipe_stall_ctrl_if.slave bus
);
    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int DCNT_W = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1;

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_IWAIT = 3'd1,
        S_DWAIT = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t              cur;
    state_t              nxt;
    logic [DCNT_W-1:0]   drain_cnt;
    logic [DCNT_W-1:0]   drain_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]    cnt;
    logic                err;
    logic                load_use;
    logic                pc_w, fd_w, dx_w, xm_w, mwb_w, fd_b, dx_b;

    assign load_use = bus.memRead_DX & bus.regWrite_DX &
                      ((bus.r1_used_FD & (bus.readRegSel1_FD == bus.writeRegSel_DX)) |
                       (bus.r2_used_FD & (bus.readRegSel2_FD == bus.writeRegSel_DX)));

    always_comb begin
        pc_w      = 1'b1;
        fd_w      = 1'b1;
        dx_w      = 1'b1;
        xm_w      = 1'b1;
        mwb_w     = 1'b1;
        fd_b      = 1'b0;
        dx_b      = 1'b0;
        nxt       = cur;
        drain_nxt = drain_cnt;
        unique case (cur)
            S_RUN, S_IWAIT, S_DWAIT: begin
                if (bus.dmem_stall) begin
                    {pc_w, fd_w, dx_w, xm_w, mwb_w} = '0;
                    nxt = S_DWAIT;
                end else if (bus.redirect_XM) begin
                    fd_b = 1'b1;
                    dx_b = 1'b1;
                    nxt  = S_RUN;
                end else if (load_use) begin
                    pc_w = 1'b0;
                    fd_w = 1'b0;
                    dx_b = 1'b1;
                    nxt  = S_RUN;
                end else if (bus.imem_stall) begin
                    pc_w = 1'b0;
                    fd_b = 1'b1;
                    nxt  = S_IWAIT;
                end else if (bus.halt_FD) begin
                    pc_w      = 1'b0;
                    fd_b      = 1'b1;
                    nxt       = S_DRAIN;
                    drain_nxt = DCNT_W'(DRAIN);
                end else begin
                    nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (bus.dmem_stall) begin
                    {pc_w, fd_w, dx_w, xm_w, mwb_w} = '0;
                end else if (bus.redirect_XM) begin
                    // HALT was on the wrong path: flush it like any other redirect.
                    fd_b = 1'b1;
                    dx_b = 1'b1;
                    nxt  = S_RUN;
                end else begin
                    pc_w      = 1'b0;
                    fd_b      = 1'b1;
                    drain_nxt = drain_cnt - 1'b1;
                    if (drain_cnt <= DCNT_W'(1)) nxt = S_HALT;
                end
            end
            S_HALT: begin
                {pc_w, fd_w, dx_w, xm_w, mwb_w} = '0;
            end
            default: nxt = S_RUN;
        endcase
        if (rst) begin
            {pc_w, fd_w, dx_w, xm_w, mwb_w} = '0;
            fd_b = 1'b0;
            dx_b = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= S_RUN;
            drain_cnt <= DCNT_W'(DRAIN);
            wait_cnt  <= '0;
            cnt       <= '0;
            err       <= 1'b0;
        end else begin
            cur       <= nxt;
            drain_cnt <= drain_nxt;
            if (!bus.dmem_stall) begin
                wait_cnt <= '0;
            end else if (cur != S_HALT) begin
                if (wait_cnt == WAIT_W'(TIMEOUT - 1)) err <= 1'b1;
                else wait_cnt <= wait_cnt + 1'b1;
            end
            if (!pc_w && cur != S_HALT && cnt != '1) cnt <= cnt + 1'b1;
        end
    end

    assign bus.pc_write    = pc_w;
    assign bus.fd_write    = fd_w;
    assign bus.fd_bubble   = fd_b;
    assign bus.dx_write    = dx_w;
    assign bus.dx_bubble   = dx_b;
    assign bus.xm_write    = xm_w;
    assign bus.mwb_write   = mwb_w;
    assign bus.state       = cur;
    assign bus.halted      = (cur == S_HALT);
    assign bus.err_timeout = err;
    assign bus.stall_cnt   = cnt;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench for pipe_stall_ctrl: a default instance plus a TIMEOUT=4, CNT_W=3
// instance sharing the same stimulus to reach the watchdog and counter saturation quickly.
module tb_pipe_stall_ctrl;
    localparam logic [4:0] W1  = 5'b11111;
    localparam logic [4:0] W0  = 5'b00000;
    localparam logic [4:0] WLU = 5'b00111;
    localparam logic [4:0] WIF = 5'b01111;
    localparam logic [2:0] RUN = 3'd0, IW = 3'd1, DW = 3'd2, DR = 3'd3, HT = 3'd4;

    typedef struct packed {
        logic       rst;
        logic [2:0] rs1, rs2, wsel;
        logic       r1u, r2u, halt, memrd, regwr, redir, imem, dmem;
    } stim_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    stim_t nx;
    int    checks = 0;
    int    errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    pipe_stall_ctrl_if #(.CNT_W(16)) bus();
    pipe_stall_ctrl_if #(.CNT_W(3))  bus_t();

    assign bus_t.readRegSel1_FD = bus.readRegSel1_FD;
    assign bus_t.readRegSel2_FD = bus.readRegSel2_FD;
    assign bus_t.r1_used_FD     = bus.r1_used_FD;
    assign bus_t.r2_used_FD     = bus.r2_used_FD;
    assign bus_t.halt_FD        = bus.halt_FD;
    assign bus_t.memRead_DX     = bus.memRead_DX;
    assign bus_t.regWrite_DX    = bus.regWrite_DX;
    assign bus_t.writeRegSel_DX = bus.writeRegSel_DX;
    assign bus_t.redirect_XM    = bus.redirect_XM;
    assign bus_t.imem_stall     = bus.imem_stall;
    assign bus_t.dmem_stall     = bus.dmem_stall;

    pipe_stall_ctrl #(.CNT_W(16), .TIMEOUT(64), .DRAIN(3)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    pipe_stall_ctrl #(.CNT_W(3), .TIMEOUT(4), .DRAIN(3)) dut_t (
        .clk(clk), .rst(rst), .bus(bus_t)
    );

    always #5 clk = ~clk;

    task automatic clr();
        nx = '0;
    endtask

    task automatic set_lu_rs1();
        nx.memrd = 1'b1; nx.regwr = 1'b1; nx.wsel = 3'd3; nx.rs1 = 3'd3; nx.r1u = 1'b1;
    endtask

    // Apply the staged inputs just after a rising edge and queue the response expected this cycle.
    task automatic step(input string name, input logic [4:0] wr, input logic fb, input logic db,
                        input logic [2:0] st, input int cnt, input logic errt);
        logic [31:0] e;
        @(posedge clk);
        #2;
        rst                = nx.rst;
        bus.readRegSel1_FD = nx.rs1;
        bus.readRegSel2_FD = nx.rs2;
        bus.r1_used_FD     = nx.r1u;
        bus.r2_used_FD     = nx.r2u;
        bus.halt_FD        = nx.halt;
        bus.memRead_DX     = nx.memrd;
        bus.regWrite_DX    = nx.regwr;
        bus.writeRegSel_DX = nx.wsel;
        bus.redirect_XM    = nx.redir;
        bus.imem_stall     = nx.imem;
        bus.dmem_stall     = nx.dmem;
        e = {wr, fb, db, st, (st == HT), 1'b0, errt, 16'(cnt), 3'((cnt > 7) ? 7 : cnt)};
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    initial begin : monitor
        logic [31:0] e, act;
        string       n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                act = {bus.pc_write, bus.fd_write, bus.dx_write, bus.xm_write, bus.mwb_write,
                       bus.fd_bubble, bus.dx_bubble, bus.state, bus.halted, bus.err_timeout,
                       bus_t.err_timeout, bus.stall_cnt, bus_t.stall_cnt};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (wr5,fb,db,st3,halted,err,err_t,cnt16,cnt_t3)",
                             n, act, e);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        clr(); nx.rst = 1'b1;
        step("reset",         W0, 0, 0, RUN, 0, 0);
        clr(); step("run0",   W1, 0, 0, RUN, 0, 0);
        clr(); set_lu_rs1();
        step("lu_rs1",        WLU, 0, 1, RUN, 0, 0);
        clr(); step("lu_clear", W1, 0, 0, RUN, 1, 0);
        clr(); nx.memrd = 1; nx.regwr = 1; nx.wsel = 5; nx.rs2 = 5; nx.rs1 = 3; nx.r1u = 1;
        step("lu_r2_unused",  W1, 0, 0, RUN, 1, 0);
        clr(); nx.memrd = 1; nx.wsel = 5; nx.rs2 = 5; nx.r2u = 1;
        step("lu_no_regwr",   W1, 0, 0, RUN, 1, 0);
        clr(); nx.memrd = 1; nx.regwr = 1; nx.wsel = 5; nx.rs2 = 5; nx.r2u = 1;
        step("lu_rs2",        WLU, 0, 1, RUN, 1, 0);
        clr(); step("lu_rs2_clear", W1, 0, 0, RUN, 2, 0);

        clr(); nx.dmem = 1;
        step("dw1",           W0, 0, 0, RUN, 2, 0);
        step("dw2",           W0, 0, 0, DW, 3, 0);
        step("dw3",           W0, 0, 0, DW, 4, 0);
        step("dw4",           W0, 0, 0, DW, 5, 0);
        clr(); step("dw_end", W1, 0, 0, DW, 6, 1);
        step("dw_run",        W1, 0, 0, RUN, 6, 1);

        clr(); nx.dmem = 1;
        step("dw2_1",         W0, 0, 0, RUN, 6, 1);
        step("dw2_2",         W0, 0, 0, DW, 7, 1);
        nx.rst = 1;
        step("async_rst",     W0, 0, 0, RUN, 0, 0);
        step("async_rst_hold", W0, 0, 0, RUN, 0, 0);
        clr(); step("rst_rel", W1, 0, 0, RUN, 0, 0);

        clr(); nx.dmem = 1;
        step("to1",           W0, 0, 0, RUN, 0, 0);
        step("to2",           W0, 0, 0, DW, 1, 0);
        step("to3",           W0, 0, 0, DW, 2, 0);
        step("to4",           W0, 0, 0, DW, 3, 0);
        step("to5",           W0, 0, 0, DW, 4, 1);
        clr(); step("to_drop", W1, 0, 0, DW, 5, 1);
        step("to_hold",       W1, 0, 0, RUN, 5, 1);

        clr(); set_lu_rs1(); nx.redir = 1; nx.imem = 1; nx.halt = 1;
        step("redir_over",    W1, 1, 1, RUN, 5, 1);
        clr(); step("redir_after", W1, 0, 0, RUN, 5, 1);
        clr(); nx.imem = 1;
        step("imem1",         WIF, 1, 0, RUN, 5, 1);
        step("imem2",         WIF, 1, 0, IW, 6, 1);
        clr(); step("imem_end", W1, 0, 0, IW, 7, 1);
        clr(); nx.dmem = 1; nx.redir = 1;
        step("pri_dmem",      W0, 0, 0, RUN, 7, 1);
        clr(); step("pri_dmem_end", W1, 0, 0, DW, 8, 1);
        clr(); set_lu_rs1(); nx.imem = 1;
        step("pri_lu",        WLU, 0, 1, RUN, 8, 1);
        clr(); step("pri_lu_after", W1, 0, 0, RUN, 9, 1);

        clr(); nx.halt = 1;
        step("halt_wp",       WIF, 1, 0, RUN, 9, 1);
        clr(); step("drain_wp", WIF, 1, 0, DR, 10, 1);
        clr(); nx.redir = 1;
        step("drain_redir",   W1, 1, 1, DR, 11, 1);
        clr(); step("wp_run", W1, 0, 0, RUN, 11, 1);

        clr(); nx.halt = 1;
        step("halt1",         WIF, 1, 0, RUN, 11, 1);
        clr(); step("drain1", WIF, 1, 0, DR, 12, 1);
        step("drain2",        WIF, 1, 0, DR, 13, 1);
        step("drain3",        WIF, 1, 0, DR, 14, 1);
        step("halted",        W0, 0, 0, HT, 15, 1);
        clr(); nx.redir = 1;
        step("halt_redir",    W0, 0, 0, HT, 15, 1);

        clr(); nx.rst = 1;
        step("rst3",          W0, 0, 0, RUN, 0, 0);
        clr(); step("rst3_rel", W1, 0, 0, RUN, 0, 0);
        clr(); nx.halt = 1;
        step("halt_s",        WIF, 1, 0, RUN, 0, 0);
        clr(); step("drain_s1", WIF, 1, 0, DR, 1, 0);
        clr(); nx.dmem = 1;
        step("drain_frz1",    W0, 0, 0, DR, 2, 0);
        step("drain_frz2",    W0, 0, 0, DR, 3, 0);
        clr(); step("drain_s2", WIF, 1, 0, DR, 4, 0);
        step("drain_s3",      WIF, 1, 0, DR, 5, 0);
        step("halted_s",      W0, 0, 0, HT, 6, 0);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
